uart_tx_fifo: RTL and testbench

- Buffered UART transmitter for the SoC serial port; drives rs232_dce_txd.
- Counterpart to the chip's serial receive path: CPU/bus side pushes bytes over a valid/ready stream into a FIFO.
- The block serialises each byte as 8N1 (optional parity), LSB first, at a fixed integer baud divisor.

---
 rtl/uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered UART transmitter. Bytes arrive over a valid/ready
//            stream into a power-of-two FIFO and are serialised onto txd
//            as start bit, 8 data bits LSB first, optional parity bit and
//            one stop bit. The bit period is a fixed integer clock divisor.
// Ports    : clk          - system clock, rising edge
//            reset_async  - asynchronous active-high reset
//            s_valid      - byte offered on s_data
//            s_ready      - FIFO can accept a byte (not full)
//            s_data[7:0]  - byte to transmit
//            txd          - serial line, idle high, registered
//            busy         - FIFO non-empty or frame in progress
//            fifo_level   - FIFO occupancy, 0..FIFO_DEPTH
// Params   : CLKS_PER_BIT (>= 2), FIFO_DEPTH (power of 2, >= 2),
//            PARITY (0 = none, 1 = odd, 2 = even)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY       = 0
) (
    input  logic                          clk,
    input  logic                          reset_async,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [7:0]                    s_data,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0]        BIT_LAST   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [7:0]       w_head;
    logic             w_par_head;
    logic [PTR_W:0]   w_level_next;

    // ------------------------------------------------------------------------
    // Transmit state
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par;
    logic              r_txd;
    logic              w_baud_done;

    // s_ready comes straight from the registered full flag, so a pop in the
    // same cycle never opens the door for a write while full.
    assign s_ready    = !r_full;
    assign w_push     = s_valid && !r_full;
    assign w_empty    = (r_level == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_baud_done = (r_baud == BAUD_LAST);

    // Parity is fixed at pop time from the whole byte, before shifting
    // destroys it. Even parity bit = XOR of data, odd = XNOR.
    assign w_par_head = (PARITY == 2) ? (^w_head) : (~^w_head);

    // The FSM consumes the head either from IDLE or at the end of a stop
    // bit, the latter giving back-to-back frames with no idle gap.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_STOP) && w_baud_done));

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // Storage carries no reset; contents are only visible through a valid
    // occupancy count, which is cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // Pointers are exactly PTR_W bits wide so they wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_next;
            r_full  <= (w_level_next == LEVEL_FULL);
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser FSM. Every non-IDLE state lasts CLKS_PER_BIT cycles; txd
    // is loaded with the next bit value on the terminal count so the line
    // changes exactly on bit boundaries.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd  <= 1'b1;
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_par   <= w_par_head;
                        r_txd   <= 1'b0;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            if (PARITY != 0) begin
                                r_txd   <= r_par;
                                r_state <= ST_PARITY;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_txd   <= 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_par   <= w_par_head;
                            r_txd   <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_baud  <= '0;
                    r_txd   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd        = r_txd;
    assign fifo_level = r_level;
    assign busy       = (r_state != ST_IDLE) || (r_level != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. Three instances share the
//            clock and reset: no parity (u_dut0), odd (u_dut1), even
//            (u_dut2), all CLKS_PER_BIT=4, FIFO_DEPTH=4. Stimulus pushes the
//            expected byte/parity into a scoreboard queue; per-instance
//            line decoders pop and compare each decoded frame.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       s_valid = '0;
    logic [7:0]       s_data = '0;
    logic [2:0]       s_ready;
    logic [2:0]       txd;
    logic [2:0]       busy;
    logic [LVL_W-1:0] lvl0;
    logic [LVL_W-1:0] lvl1;
    logic [LVL_W-1:0] lvl2;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   peak  = 0;
    exp_t exp_q[$];
    int   starts[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (int'(lvl0) > peak) peak = int'(lvl0);

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY(0)) u_dut0 (
        .clk(clk), .reset_async(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data), .txd(txd[0]), .busy(busy[0]), .fifo_level(lvl0)
    );
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY(1)) u_dut1 (
        .clk(clk), .reset_async(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data), .txd(txd[1]), .busy(busy[1]), .fifo_level(lvl1)
    );
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY(2)) u_dut2 (
        .clk(clk), .reset_async(rst), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .s_data(s_data), .txd(txd[2]), .busy(busy[2]), .fifo_level(lvl2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line decoder: detects a start bit on a falling edge and samples each
    // bit in its middle (2 cycles in, then every CPB cycles).
    task automatic monitor(input int idx, input int npar);
        logic [10:0] smp;
        logic        ab;
        int          t0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst && txd[idx] === 1'b0) begin
                t0  = cyc;
                ab  = 1'b0;
                smp = '0;
                for (int k = 0; k < 10 + npar; k++) begin
                    for (int w = 0; w < ((k == 0) ? 2 : CPB); w++) begin
                        @(negedge clk);
                        if (rst) ab = 1'b1;
                    end
                    smp[k] = txd[idx];
                end
                if (!ab) begin
                    starts.push_back(t0);
                    chk("sb_has_entry", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("sb_dut", idx, e.idx);
                        chk("sb_data", smp[8:1], e.data);
                        chk("sb_start_stop", {smp[0], smp[9 + npar]}, 2'b01);
                        if (npar != 0) chk("sb_parity", smp[9], e.par);
                    end
                end
            end
        end
    endtask

    initial monitor(0, 0);
    initial monitor(1, 1);
    initial monitor(2, 1);

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input int idx, input logic [7:0] d, input logic par, input bit track);
        int   n = 0;
        exp_t e;
        s_valid[idx] = 1'b1;
        s_data       = d;
        while (!s_ready[idx] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("send_timeout", n, 0);
        if (track) begin
            e.idx  = 2'(idx);
            e.data = d;
            e.par  = par;
            exp_q.push_back(e);
        end
        @(negedge clk);
        s_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input int limit);
        int w = 0;
        while (busy[idx] !== 1'b0 && w < limit) begin
            @(negedge clk);
            w++;
        end
        if (w >= limit) chk("idle_timeout", w, 0);
    endtask

    // Cycles from txd falling to busy dropping.
    task automatic frame_len(input int idx, output int len);
        int w = 0;
        int t0;
        while (txd[idx] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        t0 = cyc;
        w  = 0;
        while (busy[idx] !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        len = (w < 200) ? cyc - t0 : -1;
    endtask

    initial begin
        int         n;
        int         lows;
        logic [9:0] pat;
        exp_t       e;

        // ---------------- reset then idle ----------------
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("idle_others", {s_ready[2:1], busy[2:1], txd[2:1]}, 6'b110011);
        for (int i = 0; i < 100; i++) begin
            chk("idle_lines", {txd[0], s_ready[0], busy[0], lvl0},
                {1'b1, 1'b1, 1'b0, {LVL_W{1'b0}}});
            @(negedge clk);
        end

        // ---------------- single byte 0xA5 ----------------
        s_data     = 8'hA5;
        s_valid[0] = 1'b1;
        e.idx = 2'd0; e.data = 8'hA5; e.par = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        s_valid[0] = 1'b0;
        chk("a5_level_after_accept", lvl0, 1);
        chk("a5_txd_at_accept", txd[0], 1);
        @(negedge clk);
        pat = 10'b1101001010;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) repeat (CPB) @(negedge clk);
            chk("a5_line_bit", txd[0], pat[k]);
        end
        repeat (3) @(negedge clk);
        chk("a5_busy_at_39", busy[0], 1);
        @(negedge clk);
        chk("a5_busy_at_40", busy[0], 0);

        // ---------------- burst 0x00, 0xFF, 0x55 ----------------
        repeat (5) @(negedge clk);
        starts.delete();
        peak = 0;
        send(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b1);
        send(0, 8'h55, 1'b0, 1'b1);
        wait_idle(0, 400);
        chk("burst_peak_level", peak, 2);
        chk("burst_frames", starts.size(), 3);
        if (starts.size() >= 3) begin
            chk("burst_gap_1", starts[1] - starts[0], 40);
            chk("burst_gap_2", starts[2] - starts[1], 40);
            chk("burst_total", cyc - starts[0], 120);
        end

        // ---------------- fill FIFO while a frame is active ----------------
        repeat (5) @(negedge clk);
        starts.delete();
        send(0, 8'h11, 1'b0, 1'b1);
        @(negedge clk);
        send(0, 8'h22, 1'b0, 1'b1);
        send(0, 8'h33, 1'b0, 1'b1);
        send(0, 8'h44, 1'b0, 1'b1);
        send(0, 8'h66, 1'b0, 1'b1);
        chk("full_level", lvl0, 4);
        chk("full_ready", s_ready[0], 0);
        s_data     = 8'h77;
        s_valid[0] = 1'b1;
        n = 0;
        while (!s_ready[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("full_no_push_on_pop", lvl0, 3);
        e.idx = 2'd0; e.data = 8'h77; e.par = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        s_valid[0] = 1'b0;
        chk("full_accept_after_pop", lvl0, 4);
        wait_idle(0, 600);
        chk("fill_frames", starts.size(), 6);

        // ---------------- parity ----------------
        repeat (5) @(negedge clk);
        send(2, 8'h07, 1'b1, 1'b1);
        frame_len(2, n);
        chk("even_frame_len", n, 44);
        repeat (5) @(negedge clk);
        send(1, 8'h07, 1'b0, 1'b1);
        frame_len(1, n);
        chk("odd_frame_len", n, 44);

        // ---------------- reset mid-frame ----------------
        repeat (5) @(negedge clk);
        send(0, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        send(0, 8'hAA, 1'b0, 1'b0);
        send(0, 8'hBB, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_level", lvl0, 2);
        chk("pre_rst_txd_low", txd[0], 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_txd_immediate", txd[0], 1);
        chk("rst_level_immediate", lvl0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("post_rst_state", {lvl0, busy[0], s_ready[0]}, {{LVL_W{1'b0}}, 1'b0, 1'b1});
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
        end
        chk("post_rst_quiet", lows, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
